// File: rtl/btn_conditioner.sv
// Five-channel push-button conditioner: synchronise, debounce, detect presses
// and hold one pending one-hot request until the lfu consumes it.
module btn_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw1,
   input  logic raw2,
   input  logic raw3,
   input  logic raw4,
   input  logic raw5,
   input  logic timedClock,
   output logic b1,
   output logic b2,
   output logic b3,
   output logic b4,
   output logic b5,
   output logic overrun
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, HELD} state_t;

   logic [4:0]    raw;
   logic [4:0]    s1_q, s2_q;
   logic [4:0]    deb_q, deb_d;
   logic [4:0]    dly_q;
   logic [4:0]    press_q, press_d;
   logic [CW-1:0] cnt_q [5];
   logic [CW-1:0] cnt_d [5];
   logic          tc_q;
   logic          consume;
   logic [4:0]    sel;
   logic          any;
   logic          multi;
   state_t        state_q, state_d;
   logic [4:0]    b_q, b_d;
   logic          ovr_q, ovr_d;

   assign raw = {raw5, raw4, raw3, raw2, raw1};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
      end
   end

   // any cycle of agreement restarts the count from zero
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 5; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == LAST) begin
               deb_d[i] = ~deb_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign press_d = deb_q & ~dly_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 5; i++) begin
            cnt_q[i] <= '0;
         end
         deb_q   <= '0;
         dly_q   <= '0;
         press_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         for (int i = 0; i < 5; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         deb_q   <= deb_d;
         dly_q   <= deb_q;
         press_q <= press_d;
         tc_q    <= timedClock;
      end
   end

   assign consume = tc_q & ~timedClock;
   assign sel     = press_q & (~press_q + 5'd1);
   assign any     = |press_q;
   assign multi   = |(press_q & ~sel);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         b_q     <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (any) state_d = HELD;
         HELD: if (consume && !any) state_d = IDLE;
      endcase
   end

   // a press landing on the consume edge replaces the request seamlessly
   always_comb begin
      b_d   = b_q;
      ovr_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any) begin
               b_d   = sel;
               ovr_d = multi;
            end
         end
         HELD: begin
            if (consume) begin
               b_d   = any ? sel : 5'd0;
               ovr_d = multi;
            end else begin
               ovr_d = any;
            end
         end
      endcase
   end

   assign b1      = b_q[0];
   assign b2      = b_q[1];
   assign b3      = b_q[2];
   assign b4      = b_q[3];
   assign b5      = b_q[4];
   assign overrun = ovr_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncing buttons,
// checked every edge against a sample-window reference model.
module tb_btn_conditioner;

   localparam int D = 4;
   localparam int N = 4096;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] raw = '0;
   logic       tc  = 1'b0;
   logic       b1, b2, b3, b4, b5, overrun;
   logic [4:0] bv;

   int vecs = 0;
   int errs = 0;

   bit   rh [5][N];
   bit   ev [5][N+4];
   bit   tch[N];
   bit   mdeb[5];
   int   n;
   bit   held;
   int   bidx;
   bit   movr;
   logic [4:0] exp_b;
   int   ocnt;

   always #5 clk = ~clk;

   btn_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst(rst),
      .raw1(raw[0]), .raw2(raw[1]), .raw3(raw[2]),
      .raw4(raw[3]), .raw5(raw[4]),
      .timedClock(tc),
      .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5),
      .overrun(overrun)
   );

   assign bv = {b5, b4, b3, b2, b1};

   function automatic bit rs(int ch, int k);
      return (k < 1) ? 1'b0 : rh[ch][k];
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic mreset();
      n = 0; held = 0; bidx = 0; movr = 0; exp_b = '0;
      tch[0] = 0;
      for (int c = 0; c < 5; c++) begin
         mdeb[c] = 0;
         for (int k = 0; k < N + 4; k++) ev[c][k] = 0;
      end
   endtask

   // debounced level flips once the last D synchronised samples all disagree
   task automatic model(input logic [4:0] r, input logic t);
      bit all, any, cons;
      int first, cntp;
      n++;
      tch[n] = t;
      for (int c = 0; c < 5; c++) rh[c][n] = r[c];
      for (int c = 0; c < 5; c++) begin
         all = 1;
         for (int k = n - 1 - D; k <= n - 2; k++)
            if (rs(c, k) == mdeb[c]) all = 0;
         if (all) begin
            mdeb[c] = ~mdeb[c];
            if (mdeb[c]) ev[c][n+2] = 1;
         end
      end
      cons = tch[n-1] & ~tch[n];
      any = 0; first = 0; cntp = 0;
      for (int c = 4; c >= 0; c--)
         if (ev[c][n]) begin any = 1; first = c; cntp++; end
      movr = 0;
      if (!held) begin
         if (any) begin held = 1; bidx = first; movr = (cntp > 1); end
      end else if (cons) begin
         if (any) begin bidx = first; movr = (cntp > 1); end
         else held = 0;
      end else if (any) begin
         movr = 1;
      end
      exp_b = held ? (5'b1 << bidx) : 5'b0;
   endtask

   task automatic step(input logic [4:0] r, input logic t);
      raw = r; tc = t;
      @(posedge clk);
      model(r, t);
      #1;
      chk("b_model", bv, exp_b);
      chk("ovr_model", overrun, movr);
      chk("onehot", $onehot0(bv), 1);
      ocnt += overrun;
   endtask

   task automatic idle(input logic [4:0] r, input int k);
      for (int i = 0; i < k; i++) step(r, 1'b0);
   endtask

   task automatic consume_b(input logic [4:0] r);
      step(r, 1'b1);
      step(r, 1'b0);
   endtask

   initial begin
      bit [4:0] lv;
      int tcnt;
      ocnt = 0;
      mreset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_b", bv, 5'd0);
      chk("rst_ovr", overrun, 1'b0);
      rst = 1'b1;

      // single press: request appears exactly D+3 edges after first sample
      for (int i = 0; i <= D + 4; i++) begin
         step(5'b00001, 1'b0);
         chk("lat_b1", bv, (i >= D + 3) ? 5'b00001 : 5'b00000);
         chk("lat_ovr", overrun, 1'b0);
      end
      consume_b(5'b00001);
      chk("consume_b1", bv, 5'd0);
      idle(5'b00000, 10);

      // bounce then hold
      step(5'b00100, 1'b0);
      step(5'b00000, 1'b0);
      step(5'b00100, 1'b0);
      step(5'b00000, 1'b0);
      for (int i = 0; i <= D + 6; i++) begin
         step(5'b00100, 1'b0);
         chk("bounce_b3", bv, (i >= D + 3) ? 5'b00100 : 5'b00000);
      end
      consume_b(5'b00100);
      chk("hold_once", bv, 5'd0);
      idle(5'b00100, 8);
      chk("hold_no_repeat", bv, 5'd0);
      idle(5'b00000, 10);

      // press while held
      idle(5'b00010, 10);
      chk("held_b2", bv, 5'b00010);
      ocnt = 0;
      idle(5'b01010, 10);
      chk("held_keep_b2", bv, 5'b00010);
      chk("held_ovr_once", ocnt, 1);
      consume_b(5'b01010);
      chk("held_consumed", bv, 5'd0);
      for (int i = 0; i < 10; i++) begin
         step(5'b01010, 1'b0);
         chk("b4_never", bv[3], 1'b0);
      end
      idle(5'b00000, 10);

      // simultaneous presses
      ocnt = 0;
      idle(5'b10010, 10);
      chk("simul_b2", bv, 5'b00010);
      chk("simul_ovr", ocnt, 1);
      consume_b(5'b10010);
      idle(5'b00010, 10);
      idle(5'b10010, 10);
      chk("repress_b5", bv, 5'b10000);
      consume_b(5'b10010);
      idle(5'b00000, 10);

      // new press coincides with consume edge
      idle(5'b00001, 10);
      chk("pre_b1", bv, 5'b00001);
      idle(5'b00000, 10);
      for (int i = 0; i < D + 2; i++) begin
         step(5'b00001, 1'b0);
         chk("coin_b1", bv, 5'b00001);
      end
      step(5'b00001, 1'b1);
      chk("coin_b1_tick", bv, 5'b00001);
      step(5'b00001, 1'b0);
      chk("coin_b1_keep", bv, 5'b00001);
      chk("coin_ovr", overrun, 1'b0);
      consume_b(5'b00001);
      idle(5'b00000, 10);

      // asynchronous reset mid-activity
      idle(5'b01000, 10);
      idle(5'b01010, 3);
      chk("pre_rst_b4", bv, 5'b01000);
      rst = 1'b0;
      #1;
      chk("async_b", bv, 5'd0);
      chk("async_ovr", overrun, 1'b0);
      repeat (2) @(posedge clk);
      raw = 5'b00010;
      #1;
      chk("in_rst_b", bv, 5'd0);
      rst = 1'b1;
      mreset();
      for (int i = 0; i <= D + 4; i++) begin
         step(5'b00010, 1'b0);
         chk("post_rst_b2", bv, (i >= D + 3) ? 5'b00010 : 5'b00000);
      end

      // random bouncing buttons with a free-running tick
      lv = 5'b00010;
      tcnt = 0;
      for (int i = 0; i < 1500; i++) begin
         logic [4:0] r;
         for (int c = 0; c < 5; c++) begin
            if ($urandom_range(0, 39) == 0) lv[c] = ~lv[c];
            r[c] = ($urandom_range(0, 9) == 0) ? ~lv[c] : lv[c];
         end
         if (tcnt == 0) begin
            tc = ~tc;
            tcnt = $urandom_range(3, 12);
         end else begin
            tcnt--;
         end
         step(r, tc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning consecutive clk cycles a synchronised input must differ from the debounced state before that state toggles; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous release.
REQ-004 raw1..raw5  input  1 each  raw push-button levels, asynchronous to clk, 1 = pressed, may bounce.
REQ-005 timedClock  input  1  divided tick from timer, same clock domain as clk; a falling edge marks consumption by the downstream lfu.
REQ-006 b1..b5  output  1 each  registered one-hot button request to lfu; at most one high at any time.
REQ-007 overrun  output  1  registered one-cycle pulse: a debounced press was discarded.

Function
REQ-008 Each raw input SHALL pass a 2-flop synchroniser; no logic on first-stage output.
REQ-009 Each channel SHALL hold a debounced state bit and a counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-010 Counter: sync output == debounced state -> clear to 0; differs -> increment; at DEBOUNCE_CYCLES the debounced state toggles and the counter clears, same edge.
REQ-011 Any single-cycle agreement (bounce) SHALL clear the counter; no partial credit retained.
REQ-012 Press event = debounced state 0->1; release (1->0) generates no event.
REQ-013 Latency: raw held high from sample edge E produces b(n)=1 after edge E+DEBOUNCE_CYCLES+3 (7 edges at default).
REQ-014 Pending FSM, states IDLE and HELD; IDLE + press -> HELD, load one-hot b; HELD + consume -> IDLE, b cleared.
REQ-015 Consume SHALL be detected as registered timedClock = 1 and current timedClock = 0; b clears at that rising clk edge, so b is stable when lfu samples at the timedClock fall.
REQ-016 Simultaneous press events in one cycle: lowest index wins (b1 highest priority); the others discarded, overrun pulses.
REQ-017 Press in HELD without consume same cycle: press discarded, b unchanged, overrun=1 for one cycle.
REQ-018 Press and consume on the same edge: new one-hot loaded, state stays HELD, overrun=0.
REQ-019 Holding a button SHALL yield exactly one request; a further request needs release-debounce then press-debounce.
REQ-020 b SHALL never be multi-hot nor change glitch-free outside clk rising edges (all outputs driven from flops).

Reset
REQ-021 rst=0 SHALL asynchronously clear synchronisers, counters, debounced states, timedClock register, FSM (IDLE), b1..b5=0, overrun=0.
REQ-022 Reset mid-debounce or in HELD discards all progress; after release, a raw input already high SHALL produce one request after full REQ-013 latency.
REQ-023 Timer falling edge on the first cycle after reset release SHALL NOT count as consume (timedClock register resets to 0).

Verification (DEBOUNCE_CYCLES=4)
REQ-024 raw1 0->1 held, no tick -> b1=1 from edge 7 onward, b2..b5=0, overrun=0 throughout.
REQ-025 raw3 toggles 1,0,1,0 each cycle then held 1 -> no request until 7 edges after the final rise; then b3=1 once.
REQ-026 b2 held, raw4 pressed -> b2 stays 1, overrun=1 for exactly one cycle; timedClock fall -> b2=0 next edge, b4 never asserted.
REQ-027 raw2 and raw5 rise same edge -> b2=1, overrun pulse, b5=0; after consume and re-press of raw5 -> b5=1.
REQ-028 b1 held, raw1 released and re-pressed so new press coincides with consume edge -> b1 remains 1 with no zero cycle, overrun=0.
REQ-029 rst=0 asserted while b4=1 and raw2 counter mid-count -> all outputs 0 immediately without clk; after release with raw2 still high -> b2=1 at edge 7.
